// File: rtl/genius_seq_player.sv
// Plays a latched sequence of 2-bit colour codes on a one-hot LED bank, paced by a selectable slow clock.
// Optional abort support is compiled in with the macro GENIUS_SEQ_ABORT_EN.
module genius_seq_player (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        C025Hz,
    input  logic        C05Hz,
    input  logic        C1Hz,
    input  logic        C2Hz,
    input  logic [1:0]  speed,
    input  logic        start,
    input  logic [3:0]  seq_len,
    input  logic [31:0] seq_data,
    input  logic        abort,
    output logic [3:0]  led,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SHOW, S_GAP, S_FIN} state_t;

    logic [3:0]  w_slow;
    logic [3:0]  r_sync0;
    logic [3:0]  r_sync1;
    logic [3:0]  r_prev;
    logic [3:0]  r_armed;
    logic [3:0]  r_edge;
    logic [1:0]  r_vld;
    logic        w_tick;

    state_t      r_state;
    logic [1:0]  r_speed;
    logic [3:0]  r_len;
    logic [31:0] r_data;
    logic [3:0]  r_led;
    logic [3:0]  r_step;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_next_step;
    logic [1:0]  w_next_code;
    logic [3:0]  w_first_led;
    logic [3:0]  w_next_led;

    assign w_slow = {C2Hz, C1Hz, C05Hz, C025Hz};

    // Synchronise every slow input; a line only arms once a real synchronised low has been seen,
    // so an input already high when reset releases cannot fake a rising edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync0 <= 4'd0;
            r_sync1 <= 4'd0;
            r_prev  <= 4'd0;
            r_armed <= 4'd0;
            r_edge  <= 4'd0;
            r_vld   <= 2'd0;
        end else begin
            r_sync0 <= w_slow;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | ({4{r_vld[1]}} & ~r_sync1);
            r_edge  <= r_sync1 & ~r_prev & r_armed;
        end
    end

    assign w_tick      = r_edge[r_speed];
    assign w_next_step = 4'(r_step + 4'd1);
    assign w_next_code = r_data[{w_next_step, 1'b0} +: 2];
    assign w_first_led = 4'b0001 << r_data[1:0];
    assign w_next_led  = 4'b0001 << w_next_code;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_speed <= 2'd0;
            r_len   <= 4'd0;
            r_data  <= 32'd0;
            r_led   <= 4'd0;
            r_step  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led  <= 4'd0;
                    r_step <= 4'd0;
                    if (start) begin
                        r_speed <= speed;
                        r_len   <= seq_len;
                        r_data  <= seq_data;
                        r_busy  <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (w_tick) begin
                        r_step  <= 4'd0;
                        r_led   <= w_first_led;
                        r_state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_tick) begin
                        r_led   <= 4'd0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_step == r_len) begin
                            r_state <= S_FIN;
                        end else begin
                            r_step  <= w_next_step;
                            r_led   <= w_next_led;
                            r_state <= S_SHOW;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_step  <= 4'd0;
                    r_led   <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_led   <= 4'd0;
                    r_step  <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
`ifdef GENIUS_SEQ_ABORT_EN
            // Abort wins over any tick or completion handled above.
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_led   <= 4'd0;
                r_step  <= 4'd0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end
`endif
        end
    end

`ifndef GENIUS_SEQ_ABORT_EN
    logic w_unused_abort;
    assign w_unused_abort = abort;
`endif

    assign led      = r_led;
    assign step_idx = r_step;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_genius_seq_player.sv
// Directed bench for genius_seq_player: table-driven basic playback plus hand-written corner sequences.
module tb_genius_seq_player;

    logic        CLOCK_50;
    logic        reset;
    logic [3:0]  slow;
    logic [1:0]  speed;
    logic        start;
    logic [3:0]  seq_len;
    logic [31:0] seq_data;
    logic        abort;
    logic [3:0]  led;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_busy_bad = 0;

    genius_seq_player dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .C025Hz   (slow[0]),
        .C05Hz    (slow[1]),
        .C1Hz     (slow[2]),
        .C2Hz     (slow[3]),
        .speed    (speed),
        .start    (start),
        .seq_len  (seq_len),
        .seq_data (seq_data),
        .abort    (abort),
        .led      (led),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Count done pulses and note any where busy had not already dropped.
    always @(negedge CLOCK_50) begin
        if (done === 1'b1) begin
            n_done <= n_done + 1;
            if (busy !== 1'b0) n_busy_bad <= n_busy_bad + 1;
        end
    end

    typedef struct {
        int         src;
        logic [3:0] led;
        logic [3:0] idx;
        logic       busy;
        int         dn;
    } vec_t;

    vec_t tbl[7];

    task automatic step_clk(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One 20-cycle period on a slow input: exactly one rising edge.
    task automatic pulse_in(input int sel);
        slow[sel] = 1'b1;
        step_clk(10);
        slow[sel] = 1'b0;
        step_clk(10);
    endtask

    task automatic do_start(input logic [1:0] spd, input logic [3:0] len, input logic [31:0] data);
        speed    = spd;
        seq_len  = len;
        seq_data = data;
        start    = 1'b1;
        step_clk(1);
        start    = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; slow = 4'd0; speed = 2'd0; start = 1'b0;
        seq_len = 4'd0; seq_data = 32'd0; abort = 1'b0;

        tbl[0] = '{3, 4'b0001, 4'd0, 1'b1, 0};
        tbl[1] = '{3, 4'b0000, 4'd0, 1'b1, 0};
        tbl[2] = '{3, 4'b0010, 4'd1, 1'b1, 0};
        tbl[3] = '{3, 4'b0000, 4'd1, 1'b1, 0};
        tbl[4] = '{3, 4'b0100, 4'd2, 1'b1, 0};
        tbl[5] = '{3, 4'b0000, 4'd2, 1'b1, 0};
        tbl[6] = '{3, 4'b0000, 4'd0, 1'b0, 1};

        step_clk(3);
        reset = 1'b0;
        step_clk(2);
        chk("rst_led",  32'(led), 32'd0);
        chk("rst_idx",  32'(step_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Basic playback, codes 0,1,2
        base = n_done;
        do_start(2'd3, 4'd2, 32'h0000_0024);
        chk("basic_busy_start", 32'(busy), 32'd1);
        chk("basic_align_led", 32'(led), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pulse_in(tbl[i].src);
            chk($sformatf("basic_led[%0d]", i), 32'(led), 32'(tbl[i].led));
            chk($sformatf("basic_idx[%0d]", i), 32'(step_idx), 32'(tbl[i].idx));
            chk($sformatf("basic_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("basic_done[%0d]", i), 32'(n_done - base), 32'(tbl[i].dn));
        end

        // Tick latency: rise just after an edge, LED changes on the 4th edge
        base = n_done;
        do_start(2'd3, 4'd2, 32'h0000_0024);
        slow[3] = 1'b1;
        step_clk(3);
        chk("lat_edge3_led", 32'(led), 32'd0);
        step_clk(1);
        chk("lat_edge4_led", 32'(led), 32'b0001);
        step_clk(6);
        slow[3] = 1'b0;
        step_clk(10);
        for (int i = 0; i < 6; i++) pulse_in(3);
        chk("lat_done", 32'(n_done - base), 32'd1);
        chk("lat_busy_end", 32'(busy), 32'd0);

        // Rate select: only C025Hz drives playback; later input changes are ignored
        base = n_done;
        do_start(2'd0, 4'd1, 32'h0000_000B);
        speed = 2'd3; seq_data = 32'd0; seq_len = 4'd7;
        pulse_in(3);
        pulse_in(3);
        chk("rate_c2_ignored_led", 32'(led), 32'd0);
        chk("rate_c2_ignored_busy", 32'(busy), 32'd1);
        pulse_in(0);
        chk("rate_show0_led", 32'(led), 32'b1000);
        pulse_in(3);
        chk("rate_show0_hold", 32'(led), 32'b1000);
        pulse_in(0);
        chk("rate_gap0_led", 32'(led), 32'd0);
        pulse_in(0);
        chk("rate_show1_led", 32'(led), 32'b0100);
        chk("rate_show1_idx", 32'(step_idx), 32'd1);
        pulse_in(0);
        pulse_in(0);
        chk("rate_done", 32'(n_done - base), 32'd1);
        chk("rate_busy_end", 32'(busy), 32'd0);

        // Full length, start re-pulsed while busy
        base = n_done;
        do_start(2'd3, 4'd15, 32'hFFFF_FFFF);
        seq_len = 4'd0;
        for (int k = 0; k < 16; k++) begin
            pulse_in(3);
            chk($sformatf("full_show_led[%0d]", k), 32'(led), 32'b1000);
            chk($sformatf("full_show_idx[%0d]", k), 32'(step_idx), 32'(k));
            if (k == 3) begin
                speed = 2'd0; seq_data = 32'd0;
                start = 1'b1;
                step_clk(1);
                start = 1'b0;
                speed = 2'd3;
            end
            pulse_in(3);
            chk($sformatf("full_gap_led[%0d]", k), 32'(led), 32'd0);
            chk($sformatf("full_gap_busy[%0d]", k), 32'(busy), 32'd1);
        end
        pulse_in(3);
        chk("full_done", 32'(n_done - base), 32'd1);
        chk("full_idx_end", 32'(step_idx), 32'd0);
        chk("full_busy_end", 32'(busy), 32'd0);

        // Start held across FIN restarts immediately
        base = n_done;
        do_start(2'd3, 4'd0, 32'h0000_0002);
        pulse_in(3);
        chk("hold_show_led", 32'(led), 32'b0100);
        pulse_in(3);
        start = 1'b1;
        pulse_in(3);
        start = 1'b0;
        chk("hold_done", 32'(n_done - base), 32'd1);
        chk("hold_busy_again", 32'(busy), 32'd1);
        pulse_in(3);
        chk("hold_show2_led", 32'(led), 32'b0100);
        pulse_in(3);
        pulse_in(3);
        chk("hold_done2", 32'(n_done - base), 32'd2);

        // Asynchronous reset during SHOW of step 1
        base = n_done;
        do_start(2'd3, 4'd2, 32'h0000_0024);
        pulse_in(3);
        pulse_in(3);
        pulse_in(3);
        chk("rst_mid_show1_led", 32'(led), 32'b0010);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_led", 32'(led), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_idx", 32'(step_idx), 32'd0);
        slow[3] = 1'b1;
        step_clk(3);
        reset = 1'b0;
        step_clk(1);
        chk("rst_mid_no_done", 32'(n_done - base), 32'd0);

        // Input already high at reset release must not tick
        do_start(2'd3, 4'd2, 32'h0000_0024);
        step_clk(20);
        chk("rst_high_no_tick_led", 32'(led), 32'd0);
        chk("rst_high_no_tick_busy", 32'(busy), 32'd1);
        slow[3] = 1'b0;
        step_clk(10);
        pulse_in(3);
        chk("rst_first_tick_led", 32'(led), 32'b0001);
        for (int i = 0; i < 6; i++) pulse_in(3);
        chk("rst_after_done", 32'(n_done - base), 32'd1);

        // Abort during GAP
        base = n_done;
        do_start(2'd3, 4'd2, 32'h0000_0024);
        pulse_in(3);
        pulse_in(3);
        chk("abort_in_gap_led", 32'(led), 32'd0);
        abort = 1'b1;
        step_clk(1);
        abort = 1'b0;
`ifdef GENIUS_SEQ_ABORT_EN
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_idx", 32'(step_idx), 32'd0);
        chk("abort_led", 32'(led), 32'd0);
        pulse_in(3);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(n_done - base), 32'd0);
`else
        chk("noabort_busy", 32'(busy), 32'd1);
        pulse_in(3);
        chk("noabort_show1_led", 32'(led), 32'b0010);
        for (int i = 0; i < 4; i++) pulse_in(3);
        chk("noabort_done", 32'(n_done - base), 32'd1);
        chk("noabort_busy_end", 32'(busy), 32'd0);
`endif

        chk("busy_low_at_done", 32'(n_busy_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/genius_seq_player.md
GENIUS_SEQ_PLAYER -- requirements
Module: genius_seq_player

Interface
REQ-001 The block SHALL have an asynchronous, active-high reset named reset and a clock named CLOCK_50.
REQ-002 Port list, one per line (name  direction  width  meaning):
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- C025Hz, C05Hz, C1Hz, C2Hz  in  1 each  slow square waves from the clock divider, asynchronous to CLOCK_50
- speed  in  2  rate select: 0=C025Hz, 1=C05Hz, 2=C1Hz, 3=C2Hz
- start  in  1  request to play a sequence, level-sampled
- seq_len  in  4  number of steps minus 1 (1..16 steps)
- seq_data  in  32  colour codes; step k = seq_data[2k+1:2k]
- abort  in  1  cancel playback; only active under the configuration macro
- led  out  4  one-hot colour display; code c lights led[c]
- step_idx  out  4  index of the step currently being shown
- busy  out  1  high from the start acceptance through the end of playback
- done  out  1  one-cycle pulse when playback completes

Function
REQ-003 Each slow input SHALL pass through its own 2-flop synchroniser clocked by CLOCK_50.
REQ-004 A tick SHALL be a one-cycle pulse on the synchronised rising edge of the selected input.
REQ-005 Tick latency SHALL be 3 CLOCK_50 edges after the input rises: 2 synchroniser flops plus 1 edge register.
REQ-006 speed, seq_len and seq_data SHALL be latched on start acceptance; later changes SHALL NOT affect the current playback.
REQ-007 FSM states SHALL be IDLE, ALIGN, SHOW, GAP and FIN.
REQ-008 IDLE: when start=1, the block SHALL latch the inputs, set busy=1 and go to ALIGN on the next cycle.
REQ-009 ALIGN: on a tick, the block SHALL go to SHOW with step_idx=0.
REQ-010 SHOW: led SHALL equal the one-hot decode of the latched code at step_idx; on a tick, the block SHALL go to GAP.
REQ-011 GAP: led SHALL be 0; on a tick, the block SHALL go to FIN if step_idx==seq_len, otherwise increment step_idx and go to SHOW.
REQ-012 FIN: the block SHALL assert done for exactly one cycle, clear busy and step_idx, and return to IDLE.
REQ-013 led SHALL be registered and SHALL be 0 in every state except SHOW.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 start held high across FIN SHALL begin a new playback on the cycle after return to IDLE.
REQ-016 A tick arriving in the same cycle as start acceptance SHALL be ignored; ALIGN waits for the next tick.
REQ-017 Each step SHALL therefore be shown for exactly one tick period, followed by one tick period dark.
REQ-018 step_idx SHALL NOT wrap; seq_len=15 SHALL play 16 steps and then go to FIN.

Reset
REQ-019 When reset asserts, the block SHALL go to IDLE immediately, asynchronously to CLOCK_50.
REQ-020 On reset: led=0, step_idx=0, busy=0, done=0, all synchroniser and edge flops=0, latched registers=0.
REQ-021 Reset mid-playback SHALL NOT produce a done pulse.
REQ-022 After reset, the first tick SHALL require a synchronised 0->1 transition; an input already high at reset release SHALL NOT produce a tick.

Configuration
REQ-023 Abort behaviour SHALL be compiled in or out by the macro GENIUS_SEQ_ABORT_EN.
REQ-024 With GENIUS_SEQ_ABORT_EN defined: abort=1 in any state other than IDLE SHALL, on the next CLOCK_50 edge, move the block to IDLE with led=0, busy=0, step_idx=0 and no done pulse.
REQ-025 With GENIUS_SEQ_ABORT_EN defined: abort SHALL have priority over a simultaneous tick.
REQ-026 Without GENIUS_SEQ_ABORT_EN: the abort port SHALL still exist, SHALL be ignored, and SHALL drive no logic.

Verification
REQ-027 The bench SHALL drive the slow inputs directly with periods of 20-200 CLOCK_50 cycles and cover these scenarios:
- Basic playback: speed=3, seq_len=2, seq_data=0x...24 (codes 0,1,2), start pulse -> led goes 0001, 0000, 0010, 0000, 0100, 0000 on successive ticks; one done pulse; busy falls in the same cycle done rises.
- Latency: C2Hz rises at cycle N while the block is in ALIGN -> led goes non-zero at the edge N+4 (3 edges of tick latency plus 1 registered FSM update).
- Rate select: speed=0 while C2Hz also toggles -> transitions follow only C025Hz edges; speed changed mid-play -> no effect.
- Full length and busy start: seq_len=15, seq_data=0xFFFFFFFF -> 16 SHOW phases on led[3], step_idx 0..15, no wrap; start re-pulsed while busy -> ignored.
- Reset mid-play: reset asserted during SHOW of step 1 -> led=0 and busy=0 with no clock edge; done never pulses.
- Abort: with the macro defined, abort in GAP -> IDLE next cycle, no done. Without the macro, the same stimulus -> playback completes normally.
